freq_code_meter: RTL and testbench

Receiver-side companion to the team's loadable 3-bit frequency generator. That generator emits one carry pulse every 256 - 32*cnt clock cycles. This block measures the interval between successive single-cycle tick pulses on the same clock and recovers the 3-bit code. It flags illegal or missing periods and declares lock after a run of identical codes. It sits at the consuming end of the generator's carry-out line.

---
 rtl/freq_code_meter_if.sv | 23 ++
 rtl/freq_code_meter.sv | 128 ++++++++++++
 tb/tb_freq_code_meter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/freq_code_meter_if.sv
// Signal bundle between a tick source and the frequency code meter.
// The master drives tick/clr and observes results; the slave is the meter itself.
interface freq_code_meter_if #(
  parameter int M = 9
);
  logic         tick;
  logic         clr;
  logic [2:0]   code;
  logic [M-1:0] period;
  logic         meas_valid;
  logic         err;
  logic         locked;

  modport master (
    output tick, clr,
    input  code, period, meas_valid, err, locked
  );

  modport slave (
    input  tick, clr,
    output code, period, meas_valid, err, locked
  );
endinterface

// File: rtl/freq_code_meter.sv
// Measures the interval between tick pulses from the 3-bit frequency generator,
// recovers its code, flags illegal/missing periods and declares lock.
//
//   state | meaning
//   IDLE  | no reference tick seen yet (after reset, clr or timeout)
//   MEAS  | counting cycles since the last tick
module freq_code_meter #(
  parameter int M      = 9,
  parameter int LOCK_N = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  freq_code_meter_if.slave     io_meter
);

  localparam int W = (M > 9) ? M : 9;
  localparam logic [M-1:0] CNT_MAX = '1;
  localparam logic [2:0]   LOCK_CNT = 3'(LOCK_N);

  typedef enum logic {IDLE, MEAS} state_t;

  state_t       r_state, w_state_nxt;
  logic [M-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]   r_code, w_code_nxt;
  logic [M-1:0] r_period, w_period_nxt;
  logic         r_meas_valid, w_meas_valid_nxt;
  logic         r_err, w_err_nxt;
  logic [2:0]   r_match, w_match_nxt;
  logic         r_locked, w_locked_nxt;

  logic [W-1:0] w_p_ext;
  logic         w_legal;
  logic [2:0]   w_new_code;

  // Code arithmetic runs at least 9 bits wide so that P=256 maps to code 0.
  assign w_p_ext    = W'(r_cnt);
  assign w_legal    = (w_p_ext[4:0] == 5'd0) && (w_p_ext >= W'(32)) && (w_p_ext <= W'(256));
  assign w_new_code = 3'((W'(256) - w_p_ext) >> 5);

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_code_nxt       = r_code;
    w_period_nxt     = r_period;
    w_meas_valid_nxt = 1'b0;
    w_err_nxt        = 1'b0;
    w_match_nxt      = r_match;
    w_locked_nxt     = r_locked;

    case (r_state)
      IDLE: begin
        if (io_meter.tick) begin
          w_cnt_nxt   = M'(1);
          w_state_nxt = MEAS;
        end
      end
      MEAS: begin
        if (io_meter.tick) begin
          w_period_nxt = r_cnt;
          w_cnt_nxt    = M'(1);
          if (w_legal) begin
            w_code_nxt       = w_new_code;
            w_meas_valid_nxt = 1'b1;
            if ((w_new_code == r_code) && (r_match != 3'd0))
              w_match_nxt = (r_match == LOCK_CNT) ? r_match : r_match + 3'd1;
            else
              w_match_nxt = 3'd1;
            w_locked_nxt = (w_match_nxt == LOCK_CNT);
          end else begin
            w_err_nxt    = 1'b1;
            w_match_nxt  = 3'd0;
            w_locked_nxt = 1'b0;
          end
        end else if (r_cnt == CNT_MAX) begin
          w_err_nxt    = 1'b1;
          w_match_nxt  = 3'd0;
          w_locked_nxt = 1'b0;
          w_cnt_nxt    = '0;
          w_state_nxt  = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + M'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Synchronous clear wins over any tick in the same cycle.
    if (io_meter.clr) begin
      w_state_nxt      = IDLE;
      w_cnt_nxt        = '0;
      w_code_nxt       = 3'd0;
      w_period_nxt     = '0;
      w_meas_valid_nxt = 1'b0;
      w_err_nxt        = 1'b0;
      w_match_nxt      = 3'd0;
      w_locked_nxt     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_code       <= 3'd0;
      r_period     <= '0;
      r_meas_valid <= 1'b0;
      r_err        <= 1'b0;
      r_match      <= 3'd0;
      r_locked     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_code       <= w_code_nxt;
      r_period     <= w_period_nxt;
      r_meas_valid <= w_meas_valid_nxt;
      r_err        <= w_err_nxt;
      r_match      <= w_match_nxt;
      r_locked     <= w_locked_nxt;
    end
  end

  assign io_meter.code       = r_code;
  assign io_meter.period     = r_period;
  assign io_meter.meas_valid = r_meas_valid;
  assign io_meter.err        = r_err;
  assign io_meter.locked     = r_locked;

endmodule

// File: tb/tb_freq_code_meter.sv
// Bench for freq_code_meter: directed scenarios plus random tick intervals,
// every cycle compared against a time-stamp based reference model.
module tb_freq_code_meter;

  localparam int M      = 9;
  localparam int LOCK_N = 3;
  localparam int TMAX   = (1 << M) - 1;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  freq_code_meter_if #(.M(M)) u_if ();

  freq_code_meter #(.M(M), .LOCK_N(LOCK_N)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .io_meter (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: remembers when the last tick happened and the recent legal codes.
  int   m_now;
  int   m_last;
  bit   m_armed;
  int   m_code;
  int   m_period;
  bit   m_mv;
  bit   m_err;
  int   m_hist[$];

  function automatic bit model_locked();
    if (m_hist.size() < LOCK_N) return 1'b0;
    for (int i = 1; i <= LOCK_N; i++)
      if (m_hist[m_hist.size() - i] != m_hist[m_hist.size() - 1]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    m_armed  = 1'b0;
    m_code   = 0;
    m_period = 0;
    m_mv     = 1'b0;
    m_err    = 1'b0;
    m_hist.delete();
  endtask

  task automatic model_step(input bit t, input bit c);
    int p;
    m_mv  = 1'b0;
    m_err = 1'b0;
    if (c) begin
      model_clear();
    end else if (!m_armed) begin
      if (t) begin
        m_armed = 1'b1;
        m_last  = m_now;
      end
    end else begin
      p = m_now - m_last;
      if (t) begin
        m_period = p;
        m_last   = m_now;
        if ((p % 32 == 0) && p >= 32 && p <= 256) begin
          m_code = (256 - p) / 32;
          m_mv   = 1'b1;
          m_hist.push_back(m_code);
          if (m_hist.size() > LOCK_N) void'(m_hist.pop_front());
        end else begin
          m_err = 1'b1;
          m_hist.delete();
        end
      end else if (p == TMAX) begin
        m_err   = 1'b1;
        m_armed = 1'b0;
        m_hist.delete();
      end
    end
    m_now++;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, m_now);
    end
  endtask

  task automatic check_all();
    check("code",       32'(u_if.code),       32'(m_code));
    check("period",     32'(u_if.period),     32'(m_period));
    check("meas_valid", 32'(u_if.meas_valid), 32'(m_mv));
    check("err",        32'(u_if.err),        32'(m_err));
    check("locked",     32'(u_if.locked),     32'(model_locked()));
    check("mv_err_excl", 32'(u_if.meas_valid & u_if.err), 32'd0);
  endtask

  // Called at a falling edge: drives inputs for one cycle, then checks after the edge.
  task automatic cyc(input bit t, input bit c);
    u_if.tick = t;
    u_if.clr  = c;
    @(posedge clk);
    model_step(t, c);
    @(negedge clk);
    u_if.tick = 1'b0;
    u_if.clr  = 1'b0;
    check_all();
  endtask

  // Idle for n-1 cycles then tick, so the tick lands n cycles after the previous one.
  task automatic gap(input int n);
    for (int i = 1; i < n; i++) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  initial begin
    int r;
    n_checks  = 0;
    n_errors  = 0;
    m_now     = 0;
    m_last    = 0;
    model_clear();
    u_if.tick = 1'b0;
    u_if.clr  = 1'b0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;

    // Steady 256 interval: code 0, lock on third measurement.
    cyc(1'b1, 1'b0);
    repeat (3) gap(256);
    // 32 interval to code 7, then switch to 96 (code 5).
    repeat (3) gap(32);
    repeat (3) gap(96);
    // Illegal interval.
    gap(100);
    // One tick then silence to timeout, then a lone tick re-arms.
    idle(520);
    cyc(1'b1, 1'b0);
    // Lock at code 3, then clear mid-interval.
    repeat (3) gap(160);
    idle(50);
    cyc(1'b0, 1'b1);
    gap(40);
    // Tick exactly on counter 511, then 64.
    gap(511);
    gap(64);
    // Two-cycle pulse gives P=1.
    gap(64);
    cyc(1'b1, 1'b0);
    // clr and tick together.
    gap(64);
    cyc(1'b1, 1'b1);
    gap(64);

    // Random intervals biased toward legal values, with occasional clears.
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        r = 32 * $urandom_range(1, 8);
        repeat ($urandom_range(1, 3)) gap(r);
      end else if (r < 8) begin
        gap($urandom_range(1, 300));
      end else if (r == 8) begin
        idle($urandom_range(0, 20));
        cyc(1'b0, 1'b1);
      end else begin
        gap($urandom_range(500, 530));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
